// File: rtl/oram_req_sequencer.sv
// oram_req_sequencer: serial front-end that gathers store beats into an ORAM block, issues one command per request and scatters load blocks back into beats
module oram_req_sequencer #(
    parameter int NetworkWidth = 64,
    parameter int ORAMB = 512,
    parameter int ORAMU = 32,
    parameter int BECMDWidth = 3,
    parameter logic [BECMDWidth-1:0] CMD_WRITE = 3'd0,
    parameter logic [BECMDWidth-1:0] CMD_READ = 3'd2
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic [ORAMU-1:0]        ReqAddr,
    input  logic                    ReqWrite,
    input  logic                    ReqValid,
    output logic                    ReqReady,
    input  logic [NetworkWidth-1:0] WrData,
    input  logic                    WrValid,
    output logic                    WrReady,
    output logic [NetworkWidth-1:0] RdData,
    output logic                    RdValid,
    input  logic                    RdReady,
    output logic [BECMDWidth-1:0]   Cmd,
    output logic [ORAMU-1:0]        PAddr,
    output logic                    CmdValid,
    input  logic                    CmdReady,
    output logic [ORAMB-1:0]        InDataStore,
    output logic                    InDataValid,
    input  logic                    InDataReady,
    input  logic [ORAMB-1:0]        OutDataLoad,
    input  logic                    OutDataValid,
    output logic                    OutDataReady,
    output logic [31:0]             AccessCount
);
    localparam int BEATS = ORAMB / NetworkWidth;
    localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LastBeat = CW'(BEATS - 1);

    typedef enum logic [2:0] {IDLE, GATHER, CMD, WDATA, RWAIT, SCATTER} stateT;

    stateT state, nextState;
    logic [CW-1:0] beatCnt;
    logic [ORAMB-1:0] loadBuf;
    logic isWrite;
    logic reqFire, wrFire, cmdFire, inFire, outFire, rdFire, lastBeat;

    assign reqFire = ReqValid & ReqReady;
    assign wrFire = WrValid & WrReady;
    assign cmdFire = CmdValid & CmdReady;
    assign inFire = InDataValid & InDataReady;
    assign outFire = OutDataValid & OutDataReady;
    assign rdFire = RdValid & RdReady;
    assign lastBeat = beatCnt == LastBeat;

    // Next-state: each phase advances only on its own handshake, so stalls simply hold
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (reqFire) nextState = ReqWrite ? GATHER : CMD;
            GATHER:  if (wrFire && lastBeat) nextState = CMD;
            CMD:     if (cmdFire) nextState = isWrite ? WDATA : RWAIT;
            WDATA:   if (inFire) nextState = IDLE;
            RWAIT:   if (outFire) nextState = SCATTER;
            SCATTER: if (rdFire && lastBeat) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // State register and handshake flags, registered from the next state so no input reaches an output combinationally
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            ReqReady <= 1'b0;
            WrReady <= 1'b0;
            CmdValid <= 1'b0;
            InDataValid <= 1'b0;
            OutDataReady <= 1'b0;
            RdValid <= 1'b0;
        end else begin
            state <= nextState;
            ReqReady <= nextState == IDLE;
            WrReady <= nextState == GATHER;
            CmdValid <= nextState == CMD;
            InDataValid <= nextState == WDATA;
            OutDataReady <= nextState == RWAIT;
            RdValid <= nextState == SCATTER;
        end
    end

    // Datapath: request latch, beat gather/scatter with a shared beat counter, completion counter
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            beatCnt <= '0;
            isWrite <= 1'b0;
            Cmd <= '0;
            PAddr <= '0;
            InDataStore <= '0;
            loadBuf <= '0;
            RdData <= '0;
            AccessCount <= '0;
        end else begin
            if (reqFire) begin
                isWrite <= ReqWrite;
                Cmd <= ReqWrite ? CMD_WRITE : CMD_READ;
                PAddr <= ReqAddr;
                beatCnt <= '0;
            end
            if (wrFire) begin
                InDataStore[beatCnt*NetworkWidth +: NetworkWidth] <= WrData;
                beatCnt <= lastBeat ? '0 : CW'(beatCnt + 1'b1);
            end
            if (outFire) begin
                loadBuf <= OutDataLoad;
                RdData <= OutDataLoad[NetworkWidth-1:0];
                beatCnt <= '0;
            end
            if (rdFire) begin
                beatCnt <= lastBeat ? '0 : CW'(beatCnt + 1'b1);
                if (!lastBeat) RdData <= loadBuf[CW'(beatCnt + 1'b1)*NetworkWidth +: NetworkWidth];
            end
            if (inFire || (rdFire && lastBeat)) AccessCount <= AccessCount + 32'd1;
        end
    end
endmodule
